// File: rtl/mac_operand_conditioner.sv
// Two-stage operand conditioner for the lane-split unsigned MAC array: converts signed
// lane groups to magnitudes and reports each group's product sign.
module mac_operand_conditioner #(
  parameter int MAC_CONF_WIDTH = 4,
  parameter int MAC_MIN_WIDTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [MAC_CONF_WIDTH-1:0]    cfg,
  input  logic [4*MAC_MIN_WIDTH-1:0]   A_in,
  input  logic [4*MAC_MIN_WIDTH-1:0]   B_in,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [4*MAC_MIN_WIDTH-1:0]   A_mag,
  output logic [4*MAC_MIN_WIDTH-1:0]   B_mag,
  output logic                         C0_neg,
  output logic                         C1_neg,
  output logic                         C2_neg,
  output logic                         C3_neg,
  output logic [MAC_CONF_WIDTH-1:0]    cfg_out,
  output logic                         out_valid,
  input  logic                         out_ready
);
  localparam int W = MAC_MIN_WIDTH;
  localparam int N = 4 * MAC_MIN_WIDTH;

  logic       w_quad, w_dual;
  logic [3:0] w_a_msb, w_b_msb, w_sa, w_sb, w_neg, w_start;
  logic [3:0][1:0] w_top;
  logic [N-1:0] w_a_inv, w_b_inv;

  assign w_quad = (cfg[1:0] == 2'b10);
  assign w_dual = (cfg[1:0] == 2'b01);

  // Every lane inherits its group's sign from the group's top lane; the
  // group's bottom lane is where the +1 of the two's-complement negate enters.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign w_a_msb[i] = A_in[i*W+W-1];
    assign w_b_msb[i] = B_in[i*W+W-1];
    assign w_top[i]   = w_quad ? 2'(3) : (w_dual ? 2'(i | 1) : 2'(i));
    assign w_sa[i]    = cfg[3] & w_a_msb[w_top[i]];
    assign w_sb[i]    = cfg[3] & w_b_msb[w_top[i]];
    assign w_neg[i]   = w_sa[i] ^ w_sb[i];
    assign w_start[i] = w_quad ? (i == 0) : (w_dual ? (i % 2 == 0) : 1'b1);
    assign w_a_inv[i*W +: W] = A_in[i*W +: W] ^ {W{w_sa[i]}};
    assign w_b_inv[i*W +: W] = B_in[i*W +: W] ^ {W{w_sb[i]}};
  end

  logic [2:1]              r_vld_pipe;
  logic [N-1:0]            r_s1_a, r_s1_b, r_s2_a, r_s2_b;
  logic [3:0]              r_s1_sa, r_s1_sb, r_s1_neg, r_s1_start, r_s2_neg;
  logic [MAC_CONF_WIDTH-1:0] r_s1_cfg, r_s2_cfg;

  logic w_s1_adv, w_s2_adv;
  assign w_s2_adv = en & (~r_vld_pipe[2] | out_ready);
  assign w_s1_adv = en & (~r_vld_pipe[1] | w_s2_adv);
  assign in_ready = rst & w_s1_adv;

  // +1 ripple: carry restarts at each group's bottom lane, chains within the group.
  logic [N-1:0] w_a_sum, w_b_sum;
  logic         w_ca, w_cb, w_cin_a, w_cin_b;
  logic [W:0]   w_ta, w_tb;
  always_comb begin
    w_a_sum = '0;
    w_b_sum = '0;
    w_ca = 1'b0;
    w_cb = 1'b0;
    w_cin_a = 1'b0;
    w_cin_b = 1'b0;
    w_ta = '0;
    w_tb = '0;
    for (int i = 0; i < 4; i++) begin
      w_cin_a = r_s1_start[i] ? r_s1_sa[i] : w_ca;
      w_cin_b = r_s1_start[i] ? r_s1_sb[i] : w_cb;
      w_ta = {1'b0, r_s1_a[i*W +: W]} + {{W{1'b0}}, w_cin_a};
      w_tb = {1'b0, r_s1_b[i*W +: W]} + {{W{1'b0}}, w_cin_b};
      w_a_sum[i*W +: W] = w_ta[W-1:0];
      w_b_sum[i*W +: W] = w_tb[W-1:0];
      w_ca = w_ta[W];
      w_cb = w_tb[W];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld_pipe <= '0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_sa    <= '0;
      r_s1_sb    <= '0;
      r_s1_neg   <= '0;
      r_s1_start <= '0;
      r_s1_cfg   <= '0;
      r_s2_a     <= '0;
      r_s2_b     <= '0;
      r_s2_neg   <= '0;
      r_s2_cfg   <= '0;
    end else begin
      if (w_s1_adv) begin
        r_vld_pipe[1] <= in_valid;
        if (in_valid) begin
          r_s1_a     <= w_a_inv;
          r_s1_b     <= w_b_inv;
          r_s1_sa    <= w_sa;
          r_s1_sb    <= w_sb;
          r_s1_neg   <= w_neg;
          r_s1_start <= w_start;
          r_s1_cfg   <= cfg;
        end
      end
      if (w_s2_adv) begin
        r_vld_pipe[2] <= r_vld_pipe[1];
        if (r_vld_pipe[1]) begin
          r_s2_a   <= w_a_sum;
          r_s2_b   <= w_b_sum;
          r_s2_neg <= r_s1_neg;
          r_s2_cfg <= r_s1_cfg;
        end
      end
    end
  end

  assign out_valid = r_vld_pipe[2];
  assign A_mag     = r_s2_a;
  assign B_mag     = r_s2_b;
  assign C0_neg    = r_s2_neg[0];
  assign C1_neg    = r_s2_neg[1];
  assign C2_neg    = r_s2_neg[2];
  assign C3_neg    = r_s2_neg[3];
  assign cfg_out   = r_s2_cfg;
endmodule

// File: tb/tb_mac_operand_conditioner.sv
// Scoreboard bench for mac_operand_conditioner: expected beats are queued on acceptance
// and popped by a monitor whenever the DUT hands a beat downstream.
module tb_mac_operand_conditioner;
  logic        clk = 1'b0;
  logic        rst, en, in_valid, out_ready;
  logic [3:0]  cfg, cfg_out;
  logic [31:0] A_in, B_in, A_mag, B_mag;
  logic        in_ready, out_valid, C0_neg, C1_neg, C2_neg, C3_neg;
  logic [3:0]  negs;

  assign negs = {C3_neg, C2_neg, C1_neg, C0_neg};

  mac_operand_conditioner #(.MAC_CONF_WIDTH(4), .MAC_MIN_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg(cfg), .A_in(A_in), .B_in(B_in),
    .in_valid(in_valid), .in_ready(in_ready), .A_mag(A_mag), .B_mag(B_mag),
    .C0_neg(C0_neg), .C1_neg(C1_neg), .C2_neg(C2_neg), .C3_neg(C3_neg),
    .cfg_out(cfg_out), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] am;
    logic [31:0] bm;
    logic [3:0]  neg;
    logic [3:0]  cfg;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   done  = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: treat each group as one integer and negate it arithmetically.
  function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int g, gw;
    bit [63:0] va, vb, msk;
    bit sa, sb;
    e = '0;
    e.cfg = c;
    g = (c[1:0] == 2'b10) ? 4 : ((c[1:0] == 2'b01) ? 2 : 1);
    gw = g * 8;
    msk = (64'd1 << gw) - 64'd1;
    for (int s = 0; s < 4; s += g) begin
      va = ({32'd0, a} >> (s * 8)) & msk;
      vb = ({32'd0, b} >> (s * 8)) & msk;
      sa = c[3] & va[gw-1];
      sb = c[3] & vb[gw-1];
      if (sa) va = ((64'd1 << gw) - va) & msk;
      if (sb) vb = ((64'd1 << gw) - vb) & msk;
      e.am = e.am | 32'(va << (s * 8));
      e.bm = e.bm | 32'(vb << (s * 8));
      for (int k = s; k < s + g; k++) e.neg[k] = sa ^ sb;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    for (int i = 0; i < 4; i++) begin
      case ($urandom % 6)
        0: v[i*8 +: 8] = 8'h00;
        1: v[i*8 +: 8] = 8'h80;
        2: v[i*8 +: 8] = 8'hFF;
        3: v[i*8 +: 8] = 8'h7F;
        4: v[i*8 +: 8] = 8'h01;
        default: v[i*8 +: 8] = 8'($urandom);
      endcase
    end
    return v;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (in_valid && in_ready) q.push_back(model(cfg, A_in, B_in));
      if (out_valid && out_ready && en) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL sb_unexpected: got beat A_mag=%h with nothing expected", A_mag);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sb_beat", {A_mag, B_mag, negs, cfg_out}, {e.am, e.bm, e.neg, e.cfg});
        end
      end
    end
  end

  // Present one beat and hold it until accepted; returns just after the accepting edge.
  task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    int n;
    cfg = c; A_in = a; B_in = b; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 1000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 1000) chk("send_timeout", 1'b1, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic dir(input string nm, input logic [3:0] c, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] ea, input logic [31:0] eb,
                     input logic [3:0] en4);
    send(c, a, b);
    @(negedge clk);
    chk({nm, "_lat1"}, out_valid, 1'b0);
    @(negedge clk);
    chk({nm, "_lat2"}, out_valid, 1'b1);
    chk({nm, "_val"}, {A_mag, B_mag, negs}, {ea, eb, en4});
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic [79:0] snap;
    rst = 1'b0; en = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    cfg = '0; A_in = '0; B_in = '0;
    repeat (2) @(posedge clk);
    #3;
    chk("reset_state", {out_valid, in_ready, A_mag, B_mag, negs, cfg_out},
        {1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 4'd0});
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", in_ready, 1'b1);
    @(posedge clk); #1;

    dir("single_signed", 4'b1000, 32'h80FF05FB, 32'h0101FFFF, 32'h80010505, 32'h01010101, 4'b1110);
    dir("dual_signed",   4'b1001, 32'hFFFF8000, 32'h00020002, 32'h00018000, 32'h00020002, 4'b1111);
    dir("quad_signed",   4'b1010, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'h00000003, 4'b1111);
    dir("quad_unsigned", 4'b0010, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFE, 32'h00000003, 4'b0000);

    // Backpressure: third beat must be refused while both stages hold.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cfg = 4'($urandom); A_in = rand_op(); B_in = rand_op(); in_valid = 1'b1;
      @(negedge clk);
      chk("bp_in_ready", in_ready, (k < 2) ? 1'b1 : 1'b0);
      if (k < 2) begin @(posedge clk); #1; end
    end
    snap = {out_valid, A_mag, B_mag, negs, cfg_out, 7'd0};
    @(negedge clk);
    chk("bp_stable", {out_valid, A_mag, B_mag, negs, cfg_out, 7'd0}, snap);
    chk("bp_stall_ready", {out_valid, in_ready}, 2'b10);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_out0", out_valid, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_out1", out_valid, 1'b1);
    @(negedge clk);
    chk("bp_out2", out_valid, 1'b1);
    @(negedge clk);
    chk("bp_drained", out_valid, 1'b0);
    @(posedge clk); #1;

    // en low for two edges in the middle of a stream.
    fork
      begin
        for (int k = 0; k < 8; k++) send(4'($urandom), rand_op(), rand_op());
      end
      begin
        repeat (3) @(posedge clk);
        #1 en = 1'b0;
        @(negedge clk);
        snap = {out_valid, A_mag, B_mag, negs, cfg_out, 7'd0};
        chk("en_ready0", in_ready, 1'b0);
        @(negedge clk);
        chk("en_ready1", in_ready, 1'b0);
        chk("en_hold", {out_valid, A_mag, B_mag, negs, cfg_out, 7'd0}, snap);
        @(posedge clk); #1;
        chk("en_hold2", {out_valid, A_mag, B_mag, negs, cfg_out, 7'd0}, snap);
        en = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;

    // Reset with two beats in flight: both must vanish.
    out_ready = 1'b0;
    send(4'b1000, rand_op(), rand_op());
    send(4'b1001, rand_op(), rand_op());
    @(negedge clk);
    chk("rst_pre_valid", out_valid, 1'b1);
    #2 rst = 1'b0;
    q.delete();
    #1;
    chk("rst_async", {out_valid, in_ready, A_mag, negs}, {1'b0, 1'b0, 32'd0, 4'd0});
    @(posedge clk); #1;
    rst = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    dir("post_rst", 4'b1010, 32'h80000000, 32'h00000005, 32'h80000000, 32'h00000005, 4'b1111);

    // Randomized stream with input gaps and random downstream stalls.
    fork
      begin
        for (int k = 0; k < 300; k++) begin
          if ($urandom % 4 == 0) begin @(posedge clk); #1; end
          send(4'($urandom), rand_op(), rand_op());
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom % 4) != 0;
        end
      end
    join
    out_ready = 1'b1;
    for (int n = 0; n < 100 && q.size() != 0; n++) @(posedge clk);
    @(posedge clk); #1;
    chk("drain_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
